// File: rtl/seg_scan_ctrl.sv
// Two-digit multiplexed 7-segment scan controller with a timed message overlay.
// A free-running scan counter alternates the digits, and the FSM chooses what glyphs are shown.
module seg_scan_ctrl #(
  parameter int SCAN_DIV   = 100000,
  parameter int MSG_FRAMES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] val,
  input  logic [1:0] blank,
  input  logic       msg_req,
  input  logic [1:0] msg_code,
  output logic       msg_ack,
  output logic       msg_busy,
  output logic [7:0] segments
);

  // state    | meaning
  // SHOW_VAL | hex digits of val, subject to the blank bits; requests are accepted here
  // SHOW_MSG | latched message glyphs until the frame budget expires

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_TC = CW'(SCAN_DIV - 1);
  localparam int FE = (MSG_FRAMES < 1) ? 1 : MSG_FRAMES;
  localparam int FW = (FE < 2) ? 1 : $clog2(FE);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FE - 1);

  typedef enum logic {
    SHOW_VAL = 1'b0,
    SHOW_MSG = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] scan_cnt;
  logic          sel;
  logic [FW-1:0] frame_cnt;
  logic [1:0]    code_q;
  logic          scan_tc;
  logic          frame_tick;
  logic [3:0]    nib;
  logic [6:0]    glyph;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // left selects the first character of the two-letter message
  function automatic logic [6:0] msg7(input logic [1:0] code, input logic left);
    case ({code, left})
      3'b00_1: msg7 = 7'h76;
      3'b00_0: msg7 = 7'h30;
      3'b01_1: msg7 = 7'h38;
      3'b01_0: msg7 = 7'h3F;
      3'b10_1: msg7 = 7'h48;
      3'b10_0: msg7 = 7'h48;
      3'b11_1: msg7 = 7'h79;
      default: msg7 = 7'h50;
    endcase
  endfunction

  assign scan_tc    = (scan_cnt == SCAN_TC);
  assign frame_tick = scan_tc && sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      sel      <= 1'b0;
    end else if (scan_tc) begin
      scan_cnt <= '0;
      sel      <= ~sel;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    nib   = sel ? val[7:4] : val[3:0];
    glyph = 7'h00;
    if (state == SHOW_MSG)
      glyph = msg7(code_q, sel);
    else if (!blank[sel])
      glyph = hex7(nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SHOW_VAL;
      frame_cnt <= '0;
      code_q    <= 2'b00;
      segments  <= 8'h00;
      msg_ack   <= 1'b0;
      msg_busy  <= 1'b0;
    end else begin
      segments <= {sel, glyph};
      msg_ack  <= 1'b0;
      case (state)
        SHOW_VAL: begin
          if (msg_req) begin
            state     <= SHOW_MSG;
            code_q    <= msg_code;
            frame_cnt <= '0;
            msg_ack   <= 1'b1;
            msg_busy  <= 1'b1;
          end
        end
        SHOW_MSG: begin
          // requests are ignored here, so a held request is served only after the message ends
          if (frame_tick) begin
            if (frame_cnt == FRAME_LAST) begin
              state    <= SHOW_VAL;
              msg_busy <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: state <= SHOW_VAL;
      endcase
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles each digit is driven per scan slot (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter MSG_FRAMES, default 500, number of full frames (left+right slots) a message is shown; 0 SHALL behave as 1.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 val  input  8  hex value to show; [7:4] left digit, [3:0] right digit; sampled live every cycle.
REQ-007 blank  input  2  per-digit blank in value mode; [1] left, [0] right.
REQ-008 msg_req  input  1  requester holds high to request a timed message overlay.
REQ-009 msg_code  input  2  message select, sampled only on acceptance: 0 "HI", 1 "LO", 2 "==", 3 "Er".
REQ-010 msg_ack  output  1  one-cycle pulse confirming message acceptance.
REQ-011 msg_busy  output  1  high while a message is on the display.
REQ-012 segments  output  8  [6:0] = g..a, active-high; [7] = digit select, 1 left, 0 right.

Function
REQ-013 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; at terminal count digit select (sel) SHALL toggle.
REQ-014 Frame tick SHALL be the cycle sel toggles 1->0; it completes one left+right frame.
REQ-015 segments SHALL be registered: segments[7] = sel and segments[6:0] = glyph for sel's digit, both updated in the same cycle, one cycle after sel changes.
REQ-016 Hex glyphs (g..a): 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
REQ-017 Message glyphs (left, right): "HI" 76,30; "LO" 38,3F; "==" 48,48; "Er" 79,50.
REQ-018 FSM SHALL have two states, SHOW_VAL and SHOW_MSG.
REQ-019 SHOW_VAL: glyph = hex of the selected val nibble, or 00 if that digit's blank bit is set; msg_busy = 0.
REQ-020 SHOW_VAL with msg_req = 1: latch msg_code, clear frame counter, move to SHOW_MSG next cycle, with msg_ack = 1 in that same first SHOW_MSG cycle only.
REQ-021 SHOW_MSG: glyph = latched message glyph, ignoring blank and val; msg_busy = 1.
REQ-022 SHOW_MSG SHALL count frame ticks; on the MSG_FRAMES-th tick it SHALL return to SHOW_VAL next cycle.
REQ-023 msg_req while in SHOW_MSG (including the ack cycle) SHALL be ignored, with no ack and no restart of the frame count; the requester must hold msg_req to be served later.
REQ-024 msg_req held across a return to SHOW_VAL SHALL be accepted in the first SHOW_VAL cycle, giving exactly one SHOW_VAL cycle between back-to-back messages.
REQ-025 Scan timing (counter, sel) SHALL free-run and be unaffected by FSM transitions; a message may start mid-slot.
REQ-026 A message never pre-empts or shortens itself; the first partial frame counts only via the next frame tick.

Reset
REQ-027 While rst = 1 on a clk edge: scan counter = 0, sel = 0, state = SHOW_VAL, frame counter = 0, latched code = 0, segments = 8'h00, msg_ack = 0, msg_busy = 0.
REQ-028 rst during SHOW_MSG SHALL abort the message immediately with no ack; the first valid glyph appears one cycle after rst deasserts, right digit first.

Verification (SCAN_DIV=4, MSG_FRAMES=2)
REQ-029 Reset, then val=8'h3A, blank=0 -> segments alternate 8'h77 (right, 4 cycles) and 8'hCF (left, 4 cycles), repeating.
REQ-030 val=8'h3A, blank=2'b10 -> left slot shows 8'h80, right slot still 8'h77.
REQ-031 Pulse msg_req with msg_code=1 until ack -> msg_ack single cycle, msg_busy high for 2 frame ticks; left 8'hB8, right 8'h3F; then back to hex.
REQ-032 msg_req held high continuously with code 0 -> repeated "HI" messages, each separated by exactly one msg_busy=0 cycle; one ack per message.
REQ-033 rst asserted mid-message -> next cycle segments=8'h00, msg_busy=0; msg_ack never pulses for the aborted message.
REQ-034 msg_code changed after ack during SHOW_MSG -> displayed message unchanged.
